// File: rtl/avalon_arb_pkg.sv
// Shared types, default widths and helpers for the Avalon-MM read arbiter.
package avalon_arb_pkg;

  typedef enum logic [0:0] {StArb, StIssue} arb_state_e;

  localparam int unsigned DefNumMasters = 2;
  localparam int unsigned DefAddrW      = 32;
  localparam int unsigned DefDataW      = 64;
  localparam int unsigned DefMaxPend    = 4;

  // The pick function works on a fixed-width request vector; callers zero-extend.
  localparam int unsigned MaxMasters = 8;

  // Width of a master ID; kept at least 1 bit.
  function automatic int unsigned tag_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First requester at or after ptr, wrapping modulo n; returns ptr if none request.
  function automatic int unsigned rr_pick(input logic [MaxMasters-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < MaxMasters; i++) begin
      idx = (ptr + i) % n;
      if (i < n && !found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of master IDs for outstanding reads; push and pop may coincide.
module arb_tag_fifo #(
  parameter int unsigned TAG_W = 1,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             pop_i,
  output logic [TAG_W-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= tag_i;
  end

endmodule

// File: rtl/avalon_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM read slave between NUM_MASTERS readers.
// Responses are routed back in order via a tag FIFO of granted master IDs.
// Optional per-master accepted-read counters: define AVALON_ARB_PERF_CNT_EN.
module avalon_read_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DefNumMasters,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned MAX_PEND    = DefMaxPend
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]        m_read,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic [ADDR_W-1:0]             s_address,
  output logic                          s_read,
  input  logic                          s_waitrequest,
  input  logic [DATA_W-1:0]             s_readdata,
  input  logic                          s_readdatavalid,
  output logic                          busy,
  output logic                          err,
  output logic [NUM_MASTERS*16-1:0]     grant_cnt
);

  localparam int unsigned TAG_W = tag_w(NUM_MASTERS);
  localparam int unsigned CntW  = $clog2(MAX_PEND + 1);

  arb_state_e       state_q, state_d;
  logic [TAG_W-1:0] g_q, g_d;
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             err_q, err_d;
  logic             viol;
  logic             accept, pop;
  logic [TAG_W-1:0] head;
  logic             fifo_empty, fifo_full;
  logic [CntW-1:0]  pend_cnt;
  logic [MaxMasters-1:0] req_ext;

  assign req_ext = MaxMasters'(m_read);
  assign accept  = (state_q == StIssue) && m_read[g_q] && !s_waitrequest;
  assign pop     = s_readdatavalid && !fifo_empty;

  arb_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (MAX_PEND)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .tag_i   (g_q),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (pend_cnt)
  );

  // State, grant and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StArb;
      g_q      <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  // Arbitration and issue next-state; err is sticky until reset.
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    rr_ptr_d = rr_ptr_q;
    viol     = 1'b0;
    case (state_q)
      StArb: begin
        if (|m_read && !fifo_full) begin
          g_d     = TAG_W'(rr_pick(req_ext, 32'(rr_ptr_q), NUM_MASTERS));
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (accept) begin
          rr_ptr_d = (g_q == TAG_W'(NUM_MASTERS - 1)) ? '0 : g_q + 1'b1;
          state_d  = StArb;
        end else if (!m_read[g_q]) begin
          // Master withdrew its request while stalled.
          viol    = s_waitrequest;
          state_d = StArb;
        end
      end
      default: state_d = StArb;
    endcase
    err_d = err_q | viol | (s_readdatavalid & fifo_empty);
  end

  // Slave command and per-master stall/response outputs.
  always_comb begin
    s_address       = '0;
    s_read          = 1'b0;
    m_waitrequest   = '1;
    if (state_q == StIssue) begin
      s_address          = m_address[32'(g_q) * ADDR_W +: ADDR_W];
      s_read             = m_read[g_q];
      m_waitrequest[g_q] = s_waitrequest;
    end
    m_readdatavalid = pop ? (NUM_MASTERS'(1) << head) : '0;
  end

  assign m_readdata = s_readdata;
  assign busy       = (pend_cnt != '0) || (state_q == StIssue);
  assign err        = err_q;

`ifdef AVALON_ARB_PERF_CNT_EN
  logic [NUM_MASTERS-1:0][15:0] cnt_q, cnt_d;

  // Saturating accepted-read count for the granted master.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && cnt_q[g_q] != 16'hFFFF) cnt_d[g_q] = cnt_q[g_q] + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_avalon_read_arbiter.sv
// Directed bench for avalon_read_arbiter (2 masters, MAX_PEND=2).
module tb_avalon_read_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*AW-1:0]  m_address;
  logic [NM-1:0]     m_read;
  logic [NM-1:0]     m_waitrequest;
  logic [DW-1:0]     m_readdata;
  logic [NM-1:0]     m_readdatavalid;
  logic [AW-1:0]     s_address;
  logic              s_read;
  logic              s_waitrequest;
  logic [DW-1:0]     s_readdata;
  logic              s_readdatavalid;
  logic              busy;
  logic              err;
  logic [NM*16-1:0]  grant_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  avalon_read_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_PEND    (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .busy            (busy),
    .err             (err),
    .grant_cnt       (grant_cnt)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    m_address       = '0;
    m_read          = '0;
    s_waitrequest   = 1'b0;
    s_readdata      = '0;
    s_readdatavalid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (s_read !== 1'b0) begin bad++; $display("FAIL rst_s_read got=%b exp=0", s_read); end
    total++; if (s_address !== 32'h0) begin bad++; $display("FAIL rst_s_address got=%h exp=0", s_address); end
    total++; if (m_waitrequest !== 2'b11) begin bad++; $display("FAIL rst_m_wr got=%b exp=11", m_waitrequest); end
    total++; if (m_readdatavalid !== 2'b00) begin bad++; $display("FAIL rst_m_rdv got=%b exp=00", m_readdatavalid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    total++; if (grant_cnt !== 32'h0) begin bad++; $display("FAIL rst_grant_cnt got=%h exp=0", grant_cnt); end
  endtask

  task automatic test_single_read();
    do_reset();
    m_read = 2'b01; m_address[31:0] = 32'h3; s_waitrequest = 1'b1;
    #1;
    total++; if (m_waitrequest !== 2'b11) begin bad++; $display("FAIL single_arb_wr got=%b exp=11", m_waitrequest); end
    cyc(); #1;
    total++; if (s_read !== 1'b1 || s_address !== 32'h3) begin
      bad++; $display("FAIL single_issue got=%b/%h exp=1/00000003", s_read, s_address); end
    total++; if (m_waitrequest !== 2'b11) begin bad++; $display("FAIL single_stall got=%b exp=11", m_waitrequest); end
    cyc(); s_waitrequest = 1'b0; #1;
    total++; if (m_waitrequest !== 2'b10) begin bad++; $display("FAIL single_accept_wr got=%b exp=10", m_waitrequest); end
    cyc(); m_read = 2'b00; #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_pend got=%b exp=1", busy); end
    cyc(); s_readdatavalid = 1'b1; s_readdata = 64'h0102030405060708; #1;
    total++; if (m_readdatavalid !== 2'b01 || m_readdata !== 64'h0102030405060708) begin
      bad++; $display("FAIL single_resp got=%b/%h exp=01/0102030405060708", m_readdatavalid, m_readdata); end
    cyc(); s_readdatavalid = 1'b0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    int order [6];
    int n;
    int last;
    logic resp;
    logic [15:0] exp_cnt;
    do_reset();
    m_read = 2'b11; m_address = {32'h200, 32'h100}; s_waitrequest = 1'b0;
    n = 0; last = 0; resp = 1'b0;
    for (int k = 0; k < 12; k++) begin
      s_readdatavalid = resp;
      s_readdata      = 64'(k);
      #1;
      if (resp) begin
        total++;
        if (m_readdatavalid !== (2'b01 << last)) begin
          bad++; $display("FAIL rr_route got=%b exp=%b", m_readdatavalid, 2'b01 << last); end
      end
      resp = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (m_read[i] && !m_waitrequest[i]) begin
          if (n < 6) order[n] = i;
          n++; last = i; resp = 1'b1;
        end
      end
      cyc();
    end
    m_read = 2'b00; s_readdatavalid = resp;
    cyc(); s_readdatavalid = 1'b0; #1;
    total++; if (n != 6) begin bad++; $display("FAIL rr_count got=%0d exp=6", n); end
    for (int i = 0; i < 6 && i < n; i++) begin
      total++; if (order[i] != i % 2) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], i % 2); end
    end
`ifdef AVALON_ARB_PERF_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    total++; if (grant_cnt !== {exp_cnt, exp_cnt}) begin
      bad++; $display("FAIL rr_grant_cnt got=%h exp=%h", grant_cnt, {exp_cnt, exp_cnt}); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rr_err got=%b exp=0", err); end
  endtask

  task automatic test_max_pend();
    int nacc;
    do_reset();
    m_read = 2'b01; m_address[31:0] = 32'h5; s_waitrequest = 1'b0;
    nacc = 0;
    for (int k = 0; k < 8 && nacc < 2; k++) begin
      #1;
      if (m_read[0] && !m_waitrequest[0]) nacc++;
      cyc();
    end
    total++; if (nacc != 2) begin bad++; $display("FAIL pend_fill got=%0d exp=2", nacc); end
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (m_waitrequest[0] !== 1'b1 || s_read !== 1'b0) begin
        bad++; $display("FAIL pend_stall[%0d] got=%b/%b exp=1/0", k, m_waitrequest[0], s_read); end
      cyc();
    end
    s_readdatavalid = 1'b1; s_readdata = 64'hAA; #1;
    total++; if (m_readdatavalid !== 2'b01) begin bad++; $display("FAIL pend_release_rdv got=%b exp=01", m_readdatavalid); end
    cyc(); s_readdatavalid = 1'b0; #1;
    total++; if (m_waitrequest[0] !== 1'b1) begin bad++; $display("FAIL pend_release_arb got=%b exp=1", m_waitrequest[0]); end
    cyc(); #1;
    total++; if (m_waitrequest[0] !== 1'b0 || s_address !== 32'h5) begin
      bad++; $display("FAIL pend_release_acc got=%b/%h exp=0/00000005", m_waitrequest[0], s_address); end
    cyc(); m_read = 2'b00;
  endtask

  task automatic test_back_to_back();
    do_reset();
    m_read = 2'b01; m_address = {32'h8, 32'h1}; s_waitrequest = 1'b0;
    cyc(); #1;
    total++; if (s_address !== 32'h1 || m_waitrequest !== 2'b10) begin
      bad++; $display("FAIL b2b_acc0 got=%h/%b exp=00000001/10", s_address, m_waitrequest); end
    cyc(); m_read = 2'b10;
    cyc(); #1;
    total++; if (s_address !== 32'h8 || m_waitrequest !== 2'b01) begin
      bad++; $display("FAIL b2b_acc1 got=%h/%b exp=00000008/01", s_address, m_waitrequest); end
    cyc(); m_read = 2'b00; s_readdatavalid = 1'b1; s_readdata = 64'hD1; #1;
    total++; if (m_readdatavalid !== 2'b01 || m_readdata !== 64'hD1) begin
      bad++; $display("FAIL b2b_resp0 got=%b/%h exp=01/d1", m_readdatavalid, m_readdata); end
    cyc(); s_readdata = 64'hD8; #1;
    total++; if (m_readdatavalid !== 2'b10 || m_readdata !== 64'hD8) begin
      bad++; $display("FAIL b2b_resp1 got=%b/%h exp=10/d8", m_readdatavalid, m_readdata); end
    cyc(); s_readdatavalid = 1'b0; #1;
    total++; if (busy !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got=%b/%b exp=0/0", busy, err); end
  endtask

  task automatic test_spurious_resp();
    do_reset();
    s_readdatavalid = 1'b1; #1;
    total++; if (m_readdatavalid !== 2'b00) begin bad++; $display("FAIL spur_rdv got=%b exp=00", m_readdatavalid); end
    cyc(); s_readdatavalid = 1'b0; #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL spur_err got=%b exp=1", err); end
    cyc(); cyc(); #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL spur_err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid();
    int nacc;
    do_reset();
    m_read = 2'b01; s_waitrequest = 1'b0;
    nacc = 0;
    for (int k = 0; k < 8 && nacc < 2; k++) begin
      #1;
      if (m_read[0] && !m_waitrequest[0]) nacc++;
      cyc();
    end
    m_read = 2'b00;
    total++; if (nacc != 2 || busy !== 1'b1) begin
      bad++; $display("FAIL midrst_fill got=%0d/%b exp=2/1", nacc, busy); end
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    total++; if (busy !== 1'b0 || m_waitrequest !== 2'b11 || err !== 1'b0) begin
      bad++; $display("FAIL midrst_flush got=%b/%b/%b exp=0/11/0", busy, m_waitrequest, err); end
    s_readdatavalid = 1'b1; #0;
    #1;
    total++; if (m_readdatavalid !== 2'b00) begin bad++; $display("FAIL midrst_late_rdv got=%b exp=00", m_readdatavalid); end
    cyc(); s_readdatavalid = 1'b0; #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL midrst_late_err got=%b exp=1", err); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_max_pend();
    test_back_to_back();
    test_spurious_resp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
